add_sub_pipe: RTL and testbench
===============================

Name: add_sub_pipe

Overview:
- Parametrised, pipelined carry-lookahead adder/subtractor for the execute stage; successor to the fixed 32-bit combinational CLA.
- Splits a WIDTH-bit operation into STAGES segments. Each segment is a GROUP-bit lookahead block whose carry is registered into the next stage.
- Has valid/ready handshakes at input and output, full backpressure, flush, and result flags.

Parameters:
- WIDTH, 32, operand/result width; must be a multiple of STAGES.
- STAGES, 2, pipeline depth; segment width SEG = WIDTH/STAGES bits per stage; 1..8.
- GROUP, 4, lookahead group size inside a segment; SEG must be a multiple of GROUP.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush_i  in  1  synchronous kill of all in-flight operations.
- in_valid_i  in  1  operands valid.
- in_ready_o  out  1  stage 0 can accept.
- a_i  in  WIDTH  operand A.
- b_i  in  WIDTH  operand B.
- sub_i  in  1  1 = A-B, 0 = A+B.
- sat_i  in  1  signed saturate request; used only with ADD_PIPE_SAT_EN.
- out_valid_o  out  1  result valid.
- out_ready_i  in  1  consumer accepts.
- sum_o  out  WIDTH  result.
- carry_o  out  1  raw carry-out of A + B' + cin.
- ovf_o  out  1  signed overflow.
- zero_o  out  1  sum_o == 0.
- neg_o  out  1  sum_o[WIDTH-1].

Behaviour:
- Reset (rst_n low, async): all stage valid bits 0; sum_o, flags, out_valid_o = 0. in_ready_o = 1 once rst_n is released.
- Operand conditioning at stage 0: B' = sub_i ? ~b_i : b_i; cin = sub_i.
- Stage k computes bits [k*SEG +: SEG] with per-bit G = a&b', P = a|b'. Carries are lookahead per GROUP and rippled between groups. Carry-in is cin for k = 0, else the registered carry from stage k-1.
- Unprocessed upper operand slices and already-computed lower sum slices travel with the operation in skew registers.
- Latency: result is valid STAGES cycles after the accept edge when there is no backpressure. Throughput is 1 op/cycle.
- carry_o: for subtraction, 1 means no borrow.
- ovf_o = carry into MSB XOR carry out of MSB.
- zero_o and neg_o are computed on the final sum, after saturation when enabled.
- Handshake:
  - Accept when in_valid_i & in_ready_o.
  - Transfer out when out_valid_o & out_ready_i.
  - Stage k advances when stage k+1 is empty or advancing; the last stage advances on out_ready_i.
  - in_ready_o = stage 0 empty or advancing. This is combinational from out_ready_i through the chain; bubbles collapse.
- Stall: while out_valid_o=1 and out_ready_i=0, sum_o and flags are held stable. No in-flight data is lost or overwritten.
- Simultaneous accept and output transfer in a full pipe: both occur; occupancy is unchanged.
- flush_i: at the next edge all valid bits clear and out_valid_o = 0. Any input presented in the same cycle is dropped, with in_ready_o still 1. Data registers need not clear.
- Data registers load only on advance, to save toggle power.
- Reset asserted mid-operation: all in-flight ops are discarded immediately.
- STAGES=1: one registered CLA stage; latency 1.

Optional Feature:
- Macro ADD_PIPE_SAT_EN.
- Defined: on the final stage, if sat_i (carried through the pipe) and ovf_o, sum_o = the signed max 0x7FF..F when A was non-negative, else the signed min 0x800..0. ovf_o still reports 1 and carry_o is unchanged. Adds no latency.
- Undefined: sat_i is ignored (left unconnected internally) and the result is always wrapping.

Test Plan:
- WIDTH=32, STAGES=2: A=0xFFFFFFFF, B=1, add, out_ready held 1 -> two cycles later sum=0, carry=1, zero=1, ovf=0, neg=0.
- Sub A=5, B=7 -> sum=0xFFFFFFFE, carry=0, neg=1, ovf=0. Sub A=0x80000000, B=1 -> sum=0x7FFFFFFF, ovf=1, carry=1.
- Back-to-back stream of 16 random ops with random out_ready (≈50%) -> outputs are in order, match the reference model exactly, nothing is dropped or duplicated, and sum_o is stable during stalls.
- Fill the pipe with out_ready=0 -> in_ready_o falls after STAGES+1 accepts total. Then assert out_ready=1 and in_valid=1 together -> one transfer and one accept per cycle.
- flush_i pulsed with 2 ops in flight plus one presented -> out_valid_o stays 0 afterwards. The next op (A=3, B=4) gives sum=7 after STAGES cycles.
- With ADD_PIPE_SAT_EN: add 0x7FFFFFFF+1 with sat_i=1 -> sum=0x7FFFFFFF, ovf=1. Same op with sat_i=0 -> 0x80000000. Without the macro, both give 0x80000000.

Source files
------------

// File: rtl/add_sub_pipe.sv
// add_sub_pipe: pipelined carry-lookahead adder/subtractor with valid/ready flow.
// Optional signed saturation is enabled by defining ADD_PIPE_SAT_EN.
module add_sub_pipe #(
   parameter int WIDTH  = 32,
   parameter int STAGES = 2,
   parameter int GROUP  = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush_i,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic             sub_i,
   input  logic             sat_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [WIDTH-1:0] sum_o,
   output logic             carry_o,
   output logic             ovf_o,
   output logic             zero_o,
   output logic             neg_o
);
   localparam int SEG = WIDTH / STAGES;
   localparam int NG  = SEG / GROUP;
   localparam int TOP = (STAGES - 1) * SEG;

   // Slot k holds operands plus the sum bits of segments below k.
   logic [WIDTH-1:0]  a_q [STAGES];
   logic [WIDTH-1:0]  a_d [STAGES];
   logic [WIDTH-1:0]  b_q [STAGES];
   logic [WIDTH-1:0]  b_d [STAGES];
   logic [WIDTH-1:0]  s_q [STAGES];
   logic [WIDTH-1:0]  s_d [STAGES];
   logic [STAGES-1:0] c_q, c_d;
   logic [STAGES:0]   v_q, v_d, leave;
   logic              accept;
   logic [SEG+1:0]    seg_r, fin_r;
   logic [WIDTH-1:0]  fsum;
   logic              fovf;
   logic [WIDTH-1:0]  sum_q;
   logic              carry_q, ovf_q, zero_q, neg_q;
`ifdef ADD_PIPE_SAT_EN
   logic [STAGES-1:0] sat_q, sat_d;
`else
   logic              unused_sat;
   assign unused_sat = sat_i;
`endif

   // Returns {carry into MSB, carry out, sum} of one segment.
   function automatic logic [SEG+1:0] seg_add(
      input logic [SEG-1:0] a,
      input logic [SEG-1:0] b,
      input logic           ci
   );
      logic [SEG-1:0] g, p;
      logic [SEG:0]   c;
      logic           pp, t;
      g = a & b;
      p = a | b;
      c = '0;
      c[0] = ci;
      for (int gi = 0; gi < NG; gi++) begin
         for (int i = 1; i <= GROUP; i++) begin
            pp = 1'b1;
            t  = 1'b0;
            for (int j = i - 1; j >= 0; j--) begin
               t  = t | (g[gi*GROUP+j] & pp);
               pp = pp & p[gi*GROUP+j];
            end
            c[gi*GROUP+i] = t | (pp & c[gi*GROUP]);
         end
      end
      return {c[SEG-1], c[SEG], a ^ b ^ c[SEG-1:0]};
   endfunction

   always_comb begin
      leave = '0;
      leave[STAGES] = v_q[STAGES] & out_ready_i;
      for (int k = STAGES - 1; k >= 0; k--)
         leave[k] = v_q[k] & (~v_q[k+1] | leave[k+1]);
      in_ready_o = ~v_q[0] | leave[0] | flush_i;
      accept = in_valid_i & in_ready_o & ~flush_i;
      v_d = '0;
      if (!flush_i) begin
         v_d[0] = accept | (v_q[0] & ~leave[0]);
         for (int k = 1; k <= STAGES; k++)
            v_d[k] = leave[k-1] | (v_q[k] & ~leave[k]);
      end
      a_d[0] = a_i;
      b_d[0] = sub_i ? ~b_i : b_i;
      c_d[0] = sub_i;
      s_d[0] = '0;
`ifdef ADD_PIPE_SAT_EN
      sat_d[0] = sat_i;
`endif
      seg_r = '0;
      for (int k = 1; k < STAGES; k++) begin
         seg_r = seg_add(a_q[k-1][(k-1)*SEG +: SEG],
                         b_q[k-1][(k-1)*SEG +: SEG], c_q[k-1]);
         a_d[k] = a_q[k-1];
         b_d[k] = b_q[k-1];
         c_d[k] = seg_r[SEG];
         s_d[k] = s_q[k-1];
         s_d[k][(k-1)*SEG +: SEG] = seg_r[SEG-1:0];
`ifdef ADD_PIPE_SAT_EN
         sat_d[k] = sat_q[k-1];
`endif
      end
      fin_r = seg_add(a_q[STAGES-1][TOP +: SEG],
                      b_q[STAGES-1][TOP +: SEG], c_q[STAGES-1]);
      fsum = s_q[STAGES-1];
      fsum[TOP +: SEG] = fin_r[SEG-1:0];
      fovf = fin_r[SEG+1] ^ fin_r[SEG];
`ifdef ADD_PIPE_SAT_EN
      if (sat_q[STAGES-1] && fovf)
         fsum = a_q[STAGES-1][WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                       : {1'b0, {(WIDTH-1){1'b1}}};
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v_q     <= '0;
         c_q     <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
         ovf_q   <= 1'b0;
         zero_q  <= 1'b0;
         neg_q   <= 1'b0;
`ifdef ADD_PIPE_SAT_EN
         sat_q   <= '0;
`endif
         for (int k = 0; k < STAGES; k++) begin
            a_q[k] <= '0;
            b_q[k] <= '0;
            s_q[k] <= '0;
         end
      end else begin
         v_q <= v_d;
         if (accept) begin
            a_q[0] <= a_d[0];
            b_q[0] <= b_d[0];
            s_q[0] <= s_d[0];
            c_q[0] <= c_d[0];
`ifdef ADD_PIPE_SAT_EN
            sat_q[0] <= sat_d[0];
`endif
         end
         for (int k = 1; k < STAGES; k++) begin
            if (leave[k-1]) begin
               a_q[k] <= a_d[k];
               b_q[k] <= b_d[k];
               s_q[k] <= s_d[k];
               c_q[k] <= c_d[k];
`ifdef ADD_PIPE_SAT_EN
               sat_q[k] <= sat_d[k];
`endif
            end
         end
         if (leave[STAGES-1]) begin
            sum_q   <= fsum;
            carry_q <= fin_r[SEG];
            ovf_q   <= fovf;
            zero_q  <= ~|fsum;
            neg_q   <= fsum[WIDTH-1];
         end
      end
   end

   assign out_valid_o = v_q[STAGES];
   assign sum_o       = sum_q;
   assign carry_o     = carry_q;
   assign ovf_o       = ovf_q;
   assign zero_o      = zero_q;
   assign neg_o       = neg_q;

endmodule

// File: tb/tb_add_sub_pipe.sv
// tb_add_sub_pipe: randomized and directed bench for add_sub_pipe against
// an arithmetic reference model with an in-order expectation queue.
module tb_add_sub_pipe;
   localparam int W  = 32;
   localparam int ST = 2;
   localparam int GR = 4;

   typedef struct packed {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         sub;
      logic         sat;
   } op_t;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         flush_i, in_valid_i, in_ready_o;
   logic [W-1:0] a_i, b_i;
   logic         sub_i, sat_i;
   logic         out_valid_o, out_ready_i;
   logic [W-1:0] sum_o;
   logic         carry_o, ovf_o, zero_o, neg_o;

   int checks = 0;
   int passed = 0;
   op_t q[$];
   logic         prev_stall = 1'b0;
   logic [W+3:0] prev_res = '0;

   add_sub_pipe #(.WIDTH(W), .STAGES(ST), .GROUP(GR)) dut (
      .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
      .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
      .a_i(a_i), .b_i(b_i), .sub_i(sub_i), .sat_i(sat_i),
      .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
      .sum_o(sum_o), .carry_o(carry_o), .ovf_o(ovf_o),
      .zero_o(zero_o), .neg_o(neg_o)
   );

   always #5 clk = ~clk;

   // {carry, ovf, zero, neg, sum}
   function automatic logic [W+3:0] model(input op_t op);
      logic [W-1:0] bb, s;
      logic [W:0]   full;
      logic         ov;
      bb   = op.sub ? ~op.b : op.b;
      full = {1'b0, op.a} + {1'b0, bb} + {{W{1'b0}}, op.sub};
      s    = full[W-1:0];
      ov   = (op.a[W-1] == bb[W-1]) && (s[W-1] != op.a[W-1]);
`ifdef ADD_PIPE_SAT_EN
      if (op.sat && ov)
         s = op.a[W-1] ? 32'h8000_0000 : 32'h7FFF_FFFF;
`endif
      return {full[W], ov, s == '0, s[W-1], s};
   endfunction

   task automatic chk(input string nm, input logic [63:0] got,
                      input logic [63:0] exp);
      checks++;
      if (got === exp) passed++;
      else $display("FAIL %s: got %h expected %h", nm, got, exp);
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         if (prev_stall)
            chk("stall_hold", {out_valid_o, carry_o, ovf_o, zero_o, neg_o, sum_o},
                {1'b1, prev_res});
         prev_stall <= out_valid_o & ~out_ready_i;
         prev_res   <= {carry_o, ovf_o, zero_o, neg_o, sum_o};
         if (out_valid_o && out_ready_i) begin
            if (q.size() == 0) chk("extra_output", 1, 0);
            else chk("result", {carry_o, ovf_o, zero_o, neg_o, sum_o},
                     model(q.pop_front()));
         end
         if (flush_i) q.delete();
         else if (in_valid_i && in_ready_o)
            q.push_back('{a: a_i, b: b_i, sub: sub_i, sat: sat_i});
      end
   end

   task automatic newop();
      a_i   = $urandom;
      b_i   = $urandom;
      sub_i = 1'($urandom % 2);
      sat_i = 1'($urandom % 2);
      if ($urandom % 5 == 0) b_i = sub_i ? a_i : -a_i;
      if ($urandom % 5 == 0) a_i = 32'h7FFF_FFFF ^ {$urandom % 2, 31'd0};
   endtask

   task automatic drain();
      int i;
      in_valid_i  = 1'b0;
      flush_i     = 1'b0;
      out_ready_i = 1'b1;
      for (i = 0; i < 50; i++) begin
         @(posedge clk); #1;
         if (!out_valid_o && q.size() == 0) break;
      end
      if (i == 50) chk("drain_timeout", 1, 0);
   endtask

   task automatic dir(input string nm, input logic [W-1:0] a,
                      input logic [W-1:0] b, input logic sub, input logic sat,
                      input logic [W+3:0] exp);
      drain();
      a_i = a; b_i = b; sub_i = sub; sat_i = sat;
      in_valid_i = 1'b1;
      chk({nm, "_ready"}, in_ready_o, 1);
      @(posedge clk); #1;
      in_valid_i = 1'b0;
      repeat (ST) @(posedge clk);
      #1;
      chk(nm, {out_valid_o, carry_o, ovf_o, zero_o, neg_o, sum_o}, {1'b1, exp});
   endtask

   initial begin
      int n, acc, cnt;
      rst_n = 1'b0; flush_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b0;
      a_i = '0; b_i = '0; sub_i = 1'b0; sat_i = 1'b0;
      #3;
      chk("reset_out", {out_valid_o, carry_o, ovf_o, zero_o, neg_o, sum_o}, '0);
      chk("reset_ready", in_ready_o, 1);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      dir("add_wrap", 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0,
          {1'b1, 1'b0, 1'b1, 1'b0, 32'h0});
      dir("sub_borrow", 32'd5, 32'd7, 1'b1, 1'b0,
          {1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFE});
      dir("sub_ovf", 32'h8000_0000, 32'd1, 1'b1, 1'b0,
          {1'b1, 1'b1, 1'b0, 1'b0, 32'h7FFF_FFFF});

      // randomized stream under random backpressure
      drain();
      n = 0;
      newop();
      for (int c = 0; c < 400 && n < 16; c++) begin
         out_ready_i = 1'($urandom % 2);
         in_valid_i  = 1'b1;
         @(negedge clk);
         acc = int'(in_valid_i & in_ready_o);
         @(posedge clk); #1;
         if (acc != 0) begin
            n++;
            newop();
         end
      end
      in_valid_i = 1'b0;
      drain();
      chk("stream_count", n, 16);

      // fill with consumer stalled, then stream at full rate
      out_ready_i = 1'b0;
      in_valid_i  = 1'b1;
      newop();
      cnt = 0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (!in_ready_o) break;
         cnt++;
         @(posedge clk); #1;
         newop();
      end
      chk("fill_accepts", cnt, ST + 1);
      @(posedge clk); #1;
      out_ready_i = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         chk("full_rate", {in_ready_o, out_valid_o}, 2'b11);
         @(posedge clk); #1;
         newop();
      end
      in_valid_i = 1'b0;
      drain();

      // flush with two ops in flight and a third presented
      in_valid_i = 1'b1;
      newop();
      @(posedge clk); #1;
      newop();
      @(posedge clk); #1;
      newop();
      flush_i = 1'b1;
      chk("flush_ready", in_ready_o, 1);
      @(posedge clk); #1;
      flush_i = 1'b0;
      in_valid_i = 1'b0;
      for (int c = 0; c < ST + 2; c++) begin
         @(negedge clk);
         chk("flush_quiet", out_valid_o, 0);
      end
      @(posedge clk); #1;
      dir("after_flush", 32'd3, 32'd4, 1'b0, 1'b0,
          {1'b0, 1'b0, 1'b0, 1'b0, 32'd7});

`ifdef ADD_PIPE_SAT_EN
      dir("sat_on", 32'h7FFF_FFFF, 32'd1, 1'b0, 1'b1,
          {1'b0, 1'b1, 1'b0, 1'b0, 32'h7FFF_FFFF});
`else
      dir("sat_on", 32'h7FFF_FFFF, 32'd1, 1'b0, 1'b1,
          {1'b0, 1'b1, 1'b0, 1'b1, 32'h8000_0000});
`endif
      dir("sat_off", 32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0,
          {1'b0, 1'b1, 1'b0, 1'b1, 32'h8000_0000});

      // asynchronous reset with an op in flight
      drain();
      in_valid_i = 1'b1;
      newop();
      @(posedge clk); #1;
      in_valid_i = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("midreset", {out_valid_o, in_ready_o}, 2'b01);
      q.delete();
      @(posedge clk); #1;
      rst_n = 1'b1;
      for (int c = 0; c < ST + 2; c++) begin
         @(negedge clk);
         chk("midreset_quiet", out_valid_o, 0);
      end
      @(posedge clk); #1;
      drain();
      chk("queue_empty", q.size(), 0);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
